// File: rtl/axi_rd_mux_qos.sv
// rtl/axi_rd_mux_qos.sv - N-to-1 AXI4 read mux with QoS/round-robin arbitration and per-port outstanding limits
//
// Merges S_COUNT upstream AR/R channel pairs onto one downstream port.
// The downstream ID is {port_index, upstream_id}, so R beats route back by
// their upper ID bits. The AR path has one output register; the R path is
// purely combinational.

module axi_rd_mux_qos #(
   parameter int S_COUNT         = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int S_ID_WIDTH      = 8,
   parameter int M_ID_WIDTH      = S_ID_WIDTH + $clog2(S_COUNT),
   parameter int MAX_OUTSTANDING = 4,
   parameter int ARB_MODE        = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [S_COUNT*S_ID_WIDTH-1:0]   s_axi_arid,
   input  logic [S_COUNT*ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [S_COUNT*8-1:0]            s_axi_arlen,
   input  logic [S_COUNT*3-1:0]            s_axi_arsize,
   input  logic [S_COUNT*2-1:0]            s_axi_arburst,
   input  logic [S_COUNT-1:0]              s_axi_arlock,
   input  logic [S_COUNT*4-1:0]            s_axi_arqos,
   input  logic [S_COUNT-1:0]              s_axi_arvalid,
   output logic [S_COUNT-1:0]              s_axi_arready,
   output logic [S_COUNT*S_ID_WIDTH-1:0]   s_axi_rid,
   output logic [S_COUNT*DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [S_COUNT*2-1:0]            s_axi_rresp,
   output logic [S_COUNT-1:0]              s_axi_rlast,
   output logic [S_COUNT-1:0]              s_axi_rvalid,
   input  logic [S_COUNT-1:0]              s_axi_rready,
   output logic [M_ID_WIDTH-1:0]           m_axi_arid,
   output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
   output logic [7:0]                      m_axi_arlen,
   output logic [2:0]                      m_axi_arsize,
   output logic [1:0]                      m_axi_arburst,
   output logic                            m_axi_arlock,
   output logic [3:0]                      m_axi_arqos,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   input  logic [M_ID_WIDTH-1:0]           m_axi_rid,
   input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rlast,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready,
   output logic [S_COUNT*8-1:0]            outstanding_cnt,
   output logic                            route_err
);

   localparam int PW = $clog2(S_COUNT);
   localparam int IW = M_ID_WIDTH - S_ID_WIDTH;
   localparam logic [7:0]  MAX_CNT   = 8'(MAX_OUTSTANDING);
   localparam logic [PW:0] NPORT_P   = (PW+1)'(S_COUNT);
   localparam logic [IW:0] NPORT_I   = (IW+1)'(S_COUNT);
   localparam logic [PW-1:0] LAST_PORT = PW'(S_COUNT - 1);

   // state registers
   logic [S_COUNT-1:0][7:0] cnt_q, cnt_d;
   logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
   logic                    ar_valid_q, ar_valid_d;
   logic [M_ID_WIDTH-1:0]   ar_id_q, ar_id_d;
   logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
   logic [7:0]              ar_len_q, ar_len_d;
   logic [2:0]              ar_size_q, ar_size_d;
   logic [1:0]              ar_burst_q, ar_burst_d;
   logic                    ar_lock_q, ar_lock_d;
   logic [3:0]              ar_qos_q, ar_qos_d;
   logic                    route_err_q, route_err_d;

   // arbitration signals
   logic [S_COUNT-1:0]      elig;
   logic [S_COUNT-1:0]      cand;
   logic [S_COUNT-1:0]      grant_oh;
   logic [3:0]              max_qos;
   logic [PW-1:0]           gnt_idx;
   logic [PW:0]             pos;
   logic                    gnt_found;
   logic                    can_issue;
   logic                    grant_valid;

   // R routing signals
   logic [IW-1:0]           r_idx;
   logic                    route_ok;
   logic                    beat_done;
   logic [S_COUNT-1:0]      cnt_inc;
   logic [S_COUNT-1:0]      cnt_dec;

   // Eligibility (request and below limit) and, in QoS mode, keep only the highest-qos requesters
   always_comb begin
      elig    = '0;
      cand    = '0;
      max_qos = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         elig[i] = s_axi_arvalid[i] && (cnt_q[i] < MAX_CNT);
      end
      for (int i = 0; i < S_COUNT; i++) begin
         if (elig[i] && (s_axi_arqos[4*i +: 4] > max_qos)) begin
            max_qos = s_axi_arqos[4*i +: 4];
         end
      end
      cand = elig;
      if (ARB_MODE == 1) begin
         for (int i = 0; i < S_COUNT; i++) begin
            cand[i] = elig[i] && (s_axi_arqos[4*i +: 4] == max_qos);
         end
      end
   end

   // Round-robin search: first candidate at or after rr_ptr, wrapping at S_COUNT
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      pos       = '0;
      for (int k = 0; k < S_COUNT; k++) begin
         pos = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (pos >= NPORT_P) begin
            pos = pos - NPORT_P;
         end
         if (!gnt_found && cand[pos[PW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = pos[PW-1:0];
         end
      end
   end

   // Grant only when the AR register is free or draining; reset forces no grant
   always_comb begin
      can_issue   = !ar_valid_q || m_axi_arready;
      grant_valid = rst_n && can_issue && gnt_found;
      grant_oh    = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         grant_oh[i] = grant_valid && (gnt_idx == PW'(i));
      end
   end

   // AR output register next state: capture granted port fields, otherwise hold or drain
   always_comb begin
      ar_valid_d = ar_valid_q;
      ar_id_d    = ar_id_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      ar_lock_d  = ar_lock_q;
      ar_qos_d   = ar_qos_q;
      rr_ptr_d   = rr_ptr_q;
      if (grant_valid) begin
         ar_valid_d = 1'b1;
         for (int i = 0; i < S_COUNT; i++) begin
            if (grant_oh[i]) begin
               ar_id_d    = M_ID_WIDTH'({PW'(i), s_axi_arid[S_ID_WIDTH*i +: S_ID_WIDTH]});
               ar_addr_d  = s_axi_araddr[ADDR_WIDTH*i +: ADDR_WIDTH];
               ar_len_d   = s_axi_arlen[8*i +: 8];
               ar_size_d  = s_axi_arsize[3*i +: 3];
               ar_burst_d = s_axi_arburst[2*i +: 2];
               ar_lock_d  = s_axi_arlock[i];
               ar_qos_d   = s_axi_arqos[4*i +: 4];
            end
         end
         rr_ptr_d = (gnt_idx == LAST_PORT) ? '0 : gnt_idx + PW'(1);
      end else if (m_axi_arready) begin
         ar_valid_d = 1'b0;
      end
   end

   // R path: steer valid/ready by the port index in the upper ID bits; sink unroutable beats
   always_comb begin
      r_idx        = m_axi_rid[M_ID_WIDTH-1:S_ID_WIDTH];
      route_ok     = ({1'b0, r_idx} < NPORT_I);
      s_axi_rvalid = '0;
      m_axi_rready = !route_ok;
      for (int i = 0; i < S_COUNT; i++) begin
         s_axi_rid[S_ID_WIDTH*i +: S_ID_WIDTH]   = m_axi_rid[S_ID_WIDTH-1:0];
         s_axi_rdata[DATA_WIDTH*i +: DATA_WIDTH] = m_axi_rdata;
         s_axi_rresp[2*i +: 2]                   = m_axi_rresp;
         s_axi_rlast[i]                          = m_axi_rlast;
         if (route_ok && (r_idx == IW'(i))) begin
            s_axi_rvalid[i] = m_axi_rvalid;
            m_axi_rready    = s_axi_rready[i];
         end
      end
      beat_done   = m_axi_rvalid && m_axi_rready && m_axi_rlast && route_ok;
      route_err_d = m_axi_rvalid && !route_ok;
   end

   // Outstanding counters: +1 on grant, -1 on last beat, unchanged when both; never below zero
   always_comb begin
      cnt_d   = cnt_q;
      cnt_inc = '0;
      cnt_dec = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         cnt_inc[i] = grant_oh[i];
         cnt_dec[i] = beat_done && (r_idx == IW'(i));
         if (cnt_inc[i] && !cnt_dec[i]) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end else if (cnt_dec[i] && !cnt_inc[i] && (cnt_q[i] != 8'd0)) begin
            cnt_d[i] = cnt_q[i] - 8'd1;
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         rr_ptr_q    <= '0;
         ar_valid_q  <= 1'b0;
         ar_id_q     <= '0;
         ar_addr_q   <= '0;
         ar_len_q    <= '0;
         ar_size_q   <= '0;
         ar_burst_q  <= '0;
         ar_lock_q   <= 1'b0;
         ar_qos_q    <= '0;
         route_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         ar_valid_q  <= ar_valid_d;
         ar_id_q     <= ar_id_d;
         ar_addr_q   <= ar_addr_d;
         ar_len_q    <= ar_len_d;
         ar_size_q   <= ar_size_d;
         ar_burst_q  <= ar_burst_d;
         ar_lock_q   <= ar_lock_d;
         ar_qos_q    <= ar_qos_d;
         route_err_q <= route_err_d;
      end
   end

   assign s_axi_arready   = grant_oh;
   assign m_axi_arvalid   = ar_valid_q;
   assign m_axi_arid      = ar_id_q;
   assign m_axi_araddr    = ar_addr_q;
   assign m_axi_arlen     = ar_len_q;
   assign m_axi_arsize    = ar_size_q;
   assign m_axi_arburst   = ar_burst_q;
   assign m_axi_arlock    = ar_lock_q;
   assign m_axi_arqos     = ar_qos_q;
   assign outstanding_cnt = cnt_q;
   assign route_err       = route_err_q;

endmodule

// File: doc/axi_rd_mux_qos.md
# axi_rd_mux_qos

Parametrised N-to-1 AXI4 read-channel multiplexer with per-port outstanding limits and selectable round-robin or QoS-priority arbitration. It merges the read address and read data channels of S_COUNT upstream masters onto one downstream slave port. Master-side IDs are widened with the source port index so R beats can be routed back. It is used on crossbar egress paths and standalone where several initiators share one memory port.

## Interface
- S_COUNT, 4: number of slave-side (upstream) ports, 2..16
- DATA_WIDTH, 32: R data width
- ADDR_WIDTH, 32: AR address width
- S_ID_WIDTH, 8: upstream ID width
- M_ID_WIDTH, S_ID_WIDTH+$clog2(S_COUNT): downstream ID width; {port_index, s_id}
- MAX_OUTSTANDING, 4: per-port limit on accepted-but-incomplete bursts, 1..255
- ARB_MODE, 0: 0 = round-robin; 1 = highest arqos wins, round-robin tiebreak

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arqos  in  S_COUNT×{S_ID_WIDTH,ADDR_WIDTH,8,3,2,1,4}  packed upstream AR fields
- s_axi_arvalid  in  S_COUNT;  s_axi_arready  out  S_COUNT
- s_axi_rid  out  S_COUNT*S_ID_WIDTH;  s_axi_rdata  out  S_COUNT*DATA_WIDTH;  s_axi_rresp  out  S_COUNT*2;  s_axi_rlast  out  S_COUNT
- s_axi_rvalid  out  S_COUNT;  s_axi_rready  in  S_COUNT
- m_axi_arid  out  M_ID_WIDTH; m_axi_araddr/arlen/arsize/arburst/arlock/arqos  out  single-port widths as above
- m_axi_arvalid  out  1;  m_axi_arready  in  1
- m_axi_rid  in  M_ID_WIDTH;  m_axi_rdata  in  DATA_WIDTH;  m_axi_rresp  in  2;  m_axi_rlast  in  1;  m_axi_rvalid  in  1;  m_axi_rready  out  1
- outstanding_cnt  out  S_COUNT*8  per-port live burst count (zero-extended)
- route_err  out  1  one-cycle pulse when an R beat carries a port index ≥ S_COUNT

## Operation
- Eligible port: s_axi_arvalid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- Arbitration evaluated every cycle the AR output register is empty or being drained (m_axi_arvalid=0 or m_axi_arready=1).
- ARB_MODE 0: first eligible port at or after rr_ptr, wrapping at S_COUNT.
- ARB_MODE 1: among eligible, max arqos; ties resolved by same rr search.
- On grant of port g: s_axi_arready[g]=1 (only g), AR fields captured into output register, m_axi_arid={g, s_axi_arid[g]}, rr_ptr←(g+1) mod S_COUNT, cnt[g]+1.
- R path combinational: idx=m_axi_rid[M_ID_WIDTH-1:S_ID_WIDTH]; s_axi_rvalid[idx]=m_axi_rvalid, s_axi_rid[idx]=low S_ID_WIDTH bits, data/resp/last broadcast to all ports (qualified by rvalid); m_axi_rready=s_axi_rready[idx].
- idx ≥ S_COUNT: m_axi_rready=1 (beat sunk), no s_axi_rvalid, route_err=1 for that beat.
- cnt[idx]−1 on handshaked beat with rlast=1.
- Same-cycle grant to g and last-beat completion for g: cnt[g] unchanged.
- Completion when cnt[idx]=0 (protocol violation): counter saturates at 0, no underflow.

## Timing
- Reset (rst_n low, asynchronous): m_axi_arvalid=0, all s_axi_arready=0, all cnt=0, rr_ptr=0, route_err=0; AR field registers 0. Outstanding bursts are discarded; downstream must also be reset.
- AR latency: upstream handshake in cycle N → m_axi_arvalid=1 from cycle N+1, held with stable fields until m_axi_arready.
- Back-to-back: full throughput (one AR per cycle) when m_axi_arready stays 1.
- s_axi_arready is combinational from arvalid, arqos, cnt, and m_axi_arready; never asserted when no eligible port.
- R path: zero latency, no registers; rvalid/rready passthrough obeys AXI (no dependency of rvalid on rready).
- outstanding_cnt reflects registered counter (updated cycle after the handshake).
- route_err registered: pulse in cycle after the offending beat.

## Test plan
- Reset: assert rst_n=0 mid-burst with cnt[1]=3 → next sampled cycle m_axi_arvalid=0, outstanding_cnt all 0, rr_ptr=0.
- Round-robin: ARB_MODE=0, all four ports arvalid continuously, m_axi_arready=1 → grants 0,1,2,3,0…, m_axi_arid upper bits match, one AR per cycle.
- QoS: ARB_MODE=1, ports 0..3 arqos=2,7,7,1 → grants port 1, then 2, then 1 (rr tiebreak), port 0/3 only once 1/2 drop arvalid.
- Outstanding limit: MAX_OUTSTANDING=2, port 0 issues 3 ARs with no R → third held (s_axi_arready[0]=0) until an rlast beat with rid upper=0 returns; then accepted, cnt stays 2.
- R routing/backpressure: m_axi_rid={2'd2,8'h5A}, 4-beat burst, s_axi_rready[2] toggling → only s_axi_rvalid[2] high, rid=8'h5A, m_axi_rready mirrors s_axi_rready[2], cnt[2] −1 after rlast.
- Bad route + simultaneous events: S_COUNT=3, rid upper=3 → m_axi_rready=1, route_err pulse, no rvalid; same-cycle AR grant and rlast for port 0 → cnt[0] unchanged.
